// File: rtl/bcm_baseline_subtract_if.sv
// ---------------------------------------------------------------------------
// bcm_baseline_subtract_if
// Bundles the sample bus and control/status signals of bcm_baseline_subtract.
//   axiDataIn      : raw left-adjusted samples, field i = channel i/SPC, sample i%SPC
//   baselineStart  : single-cycle pulse, begin a new baseline measurement
//   baselineGate   : high on beam-free cycles whose samples feed the baseline
//   subtractEnable : 1 = subtract latched baseline, 0 = pass-through
//   axiDataOut     : corrected samples, same format as axiDataIn
//   baselineBus    : latched signed baseline per channel (channel 0 in low bits)
//   baselineValid  : a baseline has been latched since reset
//   busy           : measurement or latch in progress
// master = sample/control source, slave = the baseline-subtract block.
// ---------------------------------------------------------------------------
interface bcm_baseline_subtract_if #(
  parameter int CHANNEL_COUNT         = 2,
  parameter int AXI_SAMPLES_PER_CLOCK = 4,
  parameter int AXI_SAMPLE_WIDTH      = 16,
  parameter int ADC_WIDTH             = 14
);
  localparam int BUS_W = CHANNEL_COUNT * AXI_SAMPLES_PER_CLOCK * AXI_SAMPLE_WIDTH;

  logic [BUS_W-1:0]                   axiDataIn;
  logic                               baselineStart;
  logic                               baselineGate;
  logic                               subtractEnable;
  logic [BUS_W-1:0]                   axiDataOut;
  logic [CHANNEL_COUNT*ADC_WIDTH-1:0] baselineBus;
  logic                               baselineValid;
  logic                               busy;

  modport master (
    output axiDataIn, baselineStart, baselineGate, subtractEnable,
    input  axiDataOut, baselineBus, baselineValid, busy
  );

  modport slave (
    input  axiDataIn, baselineStart, baselineGate, subtractEnable,
    output axiDataOut, baselineBus, baselineValid, busy
  );
endinterface

// File: rtl/bcm_baseline_subtract.sv
// ---------------------------------------------------------------------------
// bcm_baseline_subtract
// Per-channel pedestal estimation and removal ahead of the BCM accumulator.
// A gated window of 2^LOG2_AVG cycles is averaged per channel (IDLE -> ACCUM
// -> UPDATE), the result is latched as the baseline, and every sample has the
// baseline subtracted (when subtractEnable) with saturation, 2-cycle latency.
// Ports:
//   adcClk   : the only clock
//   adcRstN  : asynchronous active-low reset
//   bus      : bcm_baseline_subtract_if.slave (samples, control, status)
//   satCount : per-channel 16-bit clip counters, only when the macro
//              BCM_BASELINE_SAT_COUNT_EN is defined
// ---------------------------------------------------------------------------
module bcm_baseline_subtract #(
  parameter int CHANNEL_COUNT         = 2,
  parameter int AXI_SAMPLES_PER_CLOCK = 4,
  parameter int AXI_SAMPLE_WIDTH      = 16,
  parameter int ADC_WIDTH             = 14,
  parameter int LOG2_AVG              = 10
) (
  input logic                  adcClk,
  input logic                  adcRstN,
  bcm_baseline_subtract_if.slave bus
`ifdef BCM_BASELINE_SAT_COUNT_EN
  ,
  output logic [CHANNEL_COUNT*16-1:0] satCount
`endif
);
  localparam int SPC        = AXI_SAMPLES_PER_CLOCK;
  localparam int FIELDS     = CHANNEL_COUNT * SPC;
  localparam int LOG2_SPC   = $clog2(SPC);
  localparam int ADC_SHIFT  = AXI_SAMPLE_WIDTH - ADC_WIDTH;
  localparam int AVG_SHIFT  = LOG2_AVG + LOG2_SPC;
  localparam int ACC_W      = ADC_WIDTH + AVG_SHIFT;
  localparam int CNT_W      = LOG2_AVG + 1;
  localparam int DIFF_W     = ADC_WIDTH + 1;
  localparam int CNT_FULL_I = 2 ** LOG2_AVG;
  localparam int SAT_MAX_I  = 2 ** (ADC_WIDTH - 1) - 1;
  localparam int SAT_MIN_I  = -(2 ** (ADC_WIDTH - 1));
  localparam logic [CNT_W-1:0]         CNT_FULL = CNT_FULL_I[CNT_W-1:0];
  localparam logic signed [DIFF_W-1:0] SAT_MAX  = SAT_MAX_I[DIFF_W-1:0];
  localparam logic signed [DIFF_W-1:0] SAT_MIN  = SAT_MIN_I[DIFF_W-1:0];

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

  state_t                      state_reg;
  logic                        busy_reg;
  logic                        valid_reg;
  logic [CNT_W-1:0]            cnt_reg;
  logic signed [ACC_W-1:0]     acc_reg       [CHANNEL_COUNT];
  logic signed [ACC_W-1:0]     chan_sum      [CHANNEL_COUNT];
  logic signed [ADC_WIDTH-1:0] baseline_reg  [CHANNEL_COUNT];
  logic signed [ADC_WIDTH-1:0] baseline_next [CHANNEL_COUNT];
  logic signed [ADC_WIDTH-1:0] sample        [FIELDS];
  logic signed [DIFF_W-1:0]    diff_reg      [FIELDS];
  logic [AXI_SAMPLE_WIDTH-1:0] out_reg       [FIELDS];
  logic                        clip          [FIELDS];

  // Per-field datapath: stage 1 subtract, stage 2 saturate and left-adjust.
  generate
    for (genvar gi = 0; gi < FIELDS; gi++) begin : g_field
      localparam int CH = gi / SPC;
      logic signed [ADC_WIDTH-1:0] sat_val;
      logic                        unused_lsbs;

      assign sample[gi]  = bus.axiDataIn[gi*AXI_SAMPLE_WIDTH+ADC_SHIFT +: ADC_WIDTH];
      assign unused_lsbs = ^bus.axiDataIn[gi*AXI_SAMPLE_WIDTH +: ADC_SHIFT];

      // Baseline is sampled here, so in-flight samples keep the baseline
      // that was current when they entered.
      always_ff @(posedge adcClk or negedge adcRstN) begin
        if (!adcRstN) begin
          diff_reg[gi] <= '0;
        end else if (bus.subtractEnable) begin
          diff_reg[gi] <= DIFF_W'(sample[gi]) - DIFF_W'(baseline_reg[CH]);
        end else begin
          diff_reg[gi] <= DIFF_W'(sample[gi]);
        end
      end

      always_comb begin
        clip[gi] = 1'b0;
        sat_val  = diff_reg[gi][ADC_WIDTH-1:0];
        if (diff_reg[gi] > SAT_MAX) begin
          clip[gi] = 1'b1;
          sat_val  = SAT_MAX[ADC_WIDTH-1:0];
        end else if (diff_reg[gi] < SAT_MIN) begin
          clip[gi] = 1'b1;
          sat_val  = SAT_MIN[ADC_WIDTH-1:0];
        end
      end

      always_ff @(posedge adcClk or negedge adcRstN) begin
        if (!adcRstN) begin
          out_reg[gi] <= '0;
        end else begin
          out_reg[gi] <= AXI_SAMPLE_WIDTH'($unsigned(sat_val)) << ADC_SHIFT;
        end
      end

      assign bus.axiDataOut[gi*AXI_SAMPLE_WIDTH +: AXI_SAMPLE_WIDTH] = out_reg[gi];
    end

    // Per-channel helpers: sum of this cycle's samples and the averaged value.
    for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_chan
      logic signed [ACC_W-1:0] sum_c;

      always_comb begin
        sum_c = '0;
        for (int s = 0; s < SPC; s++) begin
          sum_c = sum_c + ACC_W'(sample[gi*SPC+s]);
        end
      end

      assign chan_sum[gi]      = sum_c;
      // Arithmetic shift floors toward -inf; the average always fits ADC_WIDTH.
      assign baseline_next[gi] = ADC_WIDTH'(acc_reg[gi] >>> AVG_SHIFT);
      assign bus.baselineBus[gi*ADC_WIDTH +: ADC_WIDTH] = baseline_reg[gi];

`ifdef BCM_BASELINE_SAT_COUNT_EN
      logic        ch_clip;
      logic [15:0] sat_cnt_reg;

      always_comb begin
        ch_clip = 1'b0;
        for (int s = 0; s < SPC; s++) begin
          ch_clip = ch_clip | clip[gi*SPC+s];
        end
      end

      // Counts clock cycles in which the output register captured a clipped
      // sample of this channel; sticks at all-ones.
      always_ff @(posedge adcClk or negedge adcRstN) begin
        if (!adcRstN) begin
          sat_cnt_reg <= '0;
        end else if (bus.baselineStart) begin
          sat_cnt_reg <= '0;
        end else if (ch_clip && (sat_cnt_reg != 16'hFFFF)) begin
          sat_cnt_reg <= sat_cnt_reg + 16'd1;
        end
      end

      assign satCount[gi*16 +: 16] = sat_cnt_reg;
`else
      logic unused_clip;
      always_comb begin
        unused_clip = 1'b0;
        for (int s = 0; s < SPC; s++) begin
          unused_clip = unused_clip | clip[gi*SPC+s];
        end
      end
`endif
    end
  endgenerate

  // Baseline measurement FSM. busy is updated together with the state so it
  // tracks (state != IDLE) exactly.
  always_ff @(posedge adcClk or negedge adcRstN) begin
    if (!adcRstN) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        acc_reg[c]      <= '0;
        baseline_reg[c] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.baselineStart) begin
            state_reg <= ACCUM;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
            for (int c = 0; c < CHANNEL_COUNT; c++) acc_reg[c] <= '0;
          end
        end
        ACCUM: begin
          if (bus.baselineStart) begin
            cnt_reg <= '0;
            for (int c = 0; c < CHANNEL_COUNT; c++) acc_reg[c] <= '0;
          end else if (bus.baselineGate) begin
            cnt_reg <= cnt_reg + 1'b1;
            for (int c = 0; c < CHANNEL_COUNT; c++) acc_reg[c] <= acc_reg[c] + chan_sum[c];
            if (cnt_reg + 1'b1 == CNT_FULL) state_reg <= UPDATE;
          end
        end
        UPDATE: begin
          valid_reg <= 1'b1;
          for (int c = 0; c < CHANNEL_COUNT; c++) baseline_reg[c] <= baseline_next[c];
          // A start arriving here still lets the latch happen first.
          if (bus.baselineStart) begin
            state_reg <= ACCUM;
            cnt_reg   <= '0;
            for (int c = 0; c < CHANNEL_COUNT; c++) acc_reg[c] <= '0;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy          = busy_reg;
  assign bus.baselineValid = valid_reg;
endmodule
